// File: rtl/montgomery_final_sub_if.sv
// Request/response bundle for the Montgomery final-subtraction stage.
// The master issues start with operands; the slave returns the reduced result and status.
interface montgomery_final_sub_if;
   logic          start;
   logic [1024:0] in_x;
   logic [1023:0] in_m;
   logic [1023:0] result;
   logic          done;
   logic          busy;
   logic          err;

   modport master (
      output start, in_x, in_m,
      input  result, done, busy, err
   );

   modport slave (
      input  start, in_x, in_m,
      output result, done, busy, err
   );
endinterface

// File: rtl/montgomery_final_sub.sv
// Limb-serial final subtraction: R = x - M when x >= M, else x (x < 2M expected).
// Optional macro FINAL_SUB_LOOP_EN repeats passes until borrow, reducing x fully mod M.
module montgomery_final_sub #(
   parameter int LIMB_W   = 128,
   parameter int MAX_PASS = 4
) (
   input logic                   clk,
   input logic                   resetn,
   montgomery_final_sub_if.slave bus
);
   localparam int N_LIMBS = 1024 / LIMB_W + 1;
   localparam int TOTAL_W = N_LIMBS * LIMB_W;
   localparam int IDX_W   = $clog2(N_LIMBS + 1);
`ifdef FINAL_SUB_LOOP_EN
   localparam int DIFF_LIMBS = N_LIMBS;
   localparam int PASS_W     = $clog2(MAX_PASS + 1);
`else
   localparam int DIFF_LIMBS = N_LIMBS - 1;
`endif
   localparam int DIFF_W = DIFF_LIMBS * LIMB_W;

   if ((1024 % LIMB_W) != 0 || MAX_PASS < 1) begin : g_bad_cfg
      $error("montgomery_final_sub: LIMB_W must divide 1024 and MAX_PASS must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, SUB, SEL} state_t;

   state_t              state;
   state_t              next_state;
   logic [TOTAL_W-1:0]  x_reg;
   logic [TOTAL_W-1:0]  m_reg;
   logic [DIFF_W-1:0]   diff_reg;
   logic [IDX_W-1:0]    idx;
   logic                borrow;
   logic [1023:0]       result_reg;
   logic                done_reg;
   logic                err_reg;
   logic [LIMB_W-1:0]   x_limb;
   logic [LIMB_W-1:0]   m_limb;
   logic [LIMB_W:0]     sub_full;
`ifdef FINAL_SUB_LOOP_EN
   logic [PASS_W-1:0]   pass_cnt;
`endif

   assign x_limb   = x_reg[idx*LIMB_W +: LIMB_W];
   assign m_limb   = m_reg[idx*LIMB_W +: LIMB_W];
   // Top bit of the widened difference is the borrow out of this limb.
   assign sub_full = {1'b0, x_limb} - {1'b0, m_limb} - {{LIMB_W{1'b0}}, borrow};

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (bus.start) next_state = SUB;
         SUB:  if (idx == IDX_W'(N_LIMBS - 1)) next_state = SEL;
         SEL: begin
            next_state = IDLE;
`ifdef FINAL_SUB_LOOP_EN
            if (!borrow && pass_cnt != PASS_W'(MAX_PASS - 1)) next_state = SUB;
`endif
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.busy   = (state != IDLE);
      bus.done   = done_reg;
      bus.result = result_reg;
      bus.err    = err_reg;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_reg      <= '0;
         m_reg      <= '0;
         diff_reg   <= '0;
         idx        <= '0;
         borrow     <= 1'b0;
         result_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
`ifdef FINAL_SUB_LOOP_EN
         pass_cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  x_reg    <= {{(TOTAL_W - 1025){1'b0}}, bus.in_x};
                  m_reg    <= {{(TOTAL_W - 1024){1'b0}}, bus.in_m};
                  idx      <= '0;
                  borrow   <= 1'b0;
                  err_reg  <= 1'b0;
`ifdef FINAL_SUB_LOOP_EN
                  pass_cnt <= '0;
`endif
               end
            end
            SUB: begin
               for (int l = 0; l < DIFF_LIMBS; l++) begin
                  if (idx == IDX_W'(l)) diff_reg[l*LIMB_W +: LIMB_W] <= sub_full[LIMB_W-1:0];
               end
               borrow <= sub_full[LIMB_W];
               idx    <= idx + 1'b1;
            end
            SEL: begin
`ifdef FINAL_SUB_LOOP_EN
               if (borrow) begin
                  result_reg <= x_reg[1023:0];
                  done_reg   <= 1'b1;
               end else if (pass_cnt == PASS_W'(MAX_PASS - 1)) begin
                  result_reg <= x_reg[1023:0];
                  done_reg   <= 1'b1;
                  err_reg    <= 1'b1;
               end else begin
                  x_reg    <= diff_reg;
                  idx      <= '0;
                  borrow   <= 1'b0;
                  pass_cnt <= pass_cnt + 1'b1;
               end
`else
               result_reg <= borrow ? x_reg[1023:0] : diff_reg;
               done_reg   <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_montgomery_final_sub.sv
// Scoreboard bench for montgomery_final_sub (default build, FINAL_SUB_LOOP_EN undefined).
// Expected results and due cycles are queued at start; a negedge monitor checks each done.
module tb_montgomery_final_sub;
   logic clk;
   logic resetn;
   int   cycle;
   int   checks;
   int   passed;

   typedef struct {
      logic [1023:0] res;
      int            due;
   } exp_t;

   exp_t sb[$];

   montgomery_final_sub_if bus ();

   montgomery_final_sub dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [1023:0] got, input logic [1023:0] want);
      checks++;
      if (got === want) passed++;
      else $display("[TB] FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h",
                    name, got[1023:960], got[63:0], want[1023:960], want[63:0]);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (resetn && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_done at cycle %0d: got done=1, want no done", cycle);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result", bus.result, e.res);
            checkOutput("latency", 1024'(cycle), 1024'(e.due));
            checkOutput("err_low", 1024'(bus.err), 1024'(0));
            checkOutput("busy_low_at_done", 1024'(bus.busy), 1024'(0));
         end
      end
   end

   task automatic applyStimulus(input logic [1024:0] x, input logic [1023:0] m,
                                input logic [1023:0] want, input bit push);
      bus.start = 1'b1;
      bus.in_x  = x;
      bus.in_m  = m;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.in_x  = '1;
      bus.in_m  = 1024'd5;
      if (push) sb.push_back('{want, cycle + 10});
   endtask

   task automatic waitDone(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         $display("[TB] FAIL %s_timeout: got no done in 30 cycles, want done", name);
      end
   endtask

   initial begin
      logic [1024:0] big_x;
      logic [1023:0] big_m;
      logic [1023:0] big_r;

      cycle     = 0;
      checks    = 0;
      passed    = 0;
      resetn    = 1'b0;
      bus.start = 1'b0;
      bus.in_x  = '0;
      bus.in_m  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_result", bus.result, '0);
      checkOutput("reset_done", 1024'(bus.done), 1024'(0));
      checkOutput("reset_busy", 1024'(bus.busy), 1024'(0));
      checkOutput("reset_err", 1024'(bus.err), 1024'(0));
      resetn = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1025'd3, 1024'd7, 1024'd3, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("busy_mid_op", 1024'(bus.busy), 1024'(1));
      waitDone("x3_m7");
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", 1024'(bus.done), 1024'(0));

      applyStimulus(1025'd12, 1024'd7, 1024'd5, 1'b1);
      waitDone("x12_m7");
      applyStimulus(1025'd7, 1024'd7, 1024'd0, 1'b1);
      waitDone("x7_m7");
      applyStimulus(1025'd6, 1024'd7, 1024'd6, 1'b1);
      waitDone("x6_m7");

      big_x = 1025'd1;
      big_x = big_x << 1024;
      big_m = 1024'd1;
      big_m = (big_m << 1023) + 1024'd1;
      big_r = 1024'd1;
      big_r = (big_r << 1023) - 1024'd1;
      applyStimulus(big_x, big_m, big_r, 1'b1);
      waitDone("top_limb");

      applyStimulus(1025'd5, 1024'd0, 1024'd5, 1'b1);
      waitDone("m_zero");

      // Start during busy must be ignored; start on the done cycle is accepted.
      applyStimulus(1025'd12, 1024'd7, 1024'd5, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.in_x  = 1025'd3;
      bus.in_m  = 1024'd100;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("busy_after_ignored_start", 1024'(bus.busy), 1024'(1));
      waitDone("ignored_start");
      applyStimulus(1025'd20, 1024'd11, 1024'd9, 1'b1);
      waitDone("back_to_back");

      // Mid-operation reset discards the in-flight result.
      applyStimulus(1025'd12, 1024'd7, 1024'd5, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      checkOutput("midreset_result", bus.result, '0);
      checkOutput("midreset_done", 1024'(bus.done), 1024'(0));
      checkOutput("midreset_busy", 1024'(bus.busy), 1024'(0));
      repeat (15) @(posedge clk);
      #1;
      applyStimulus(1025'd6, 1024'd7, 1024'd6, 1'b1);
      waitDone("after_reset");

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", 1024'(sb.size()), 1024'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
